// File: rtl/seq_scan_arbiter.sv
// Round-robin arbiter sharing one serial, non-overlapping pattern detector.
// The granted channel's word is shifted MSB-first through a 4-bit window.
// Non-overlapping matches are counted, and the count is reported with a
// done pulse tagged by the channel ID.
module seq_scan_arbiter #(
  parameter int           NCH   = 4,
  parameter int           IDW   = 2,
  parameter int           WIDTH = 16,
  parameter logic [3:0]   PAT   = 4'b1011,
  parameter int           CNTW  = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NCH-1:0]         req,
  input  logic [NCH*WIDTH-1:0]   data,
  output logic [NCH-1:0]         gnt,
  output logic                   busy,
  output logic                   found,
  output logic                   done,
  output logic [IDW-1:0]         done_id,
  output logic [CNTW-1:0]        match_cnt
);

  localparam int BCW = $clog2(WIDTH);
  localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};
  localparam logic [CNTW-1:0] CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [IDW-1:0]    r_ptr;
  logic [WIDTH-1:0]  r_shreg;
  logic [BCW-1:0]    r_bitcnt;
  logic [3:0]        r_win;
  logic [2:0]        r_fill;
  logic [CNTW-1:0]   r_cnt;

  logic              w_win_vld;
  logic [IDW-1:0]    w_win_id;
  logic [IDW-1:0]    w_cand;
  logic [WIDTH-1:0]  w_word;
  logic [NCH-1:0]    w_onehot;
  logic              w_bit;
  logic [3:0]        w_win_nxt;
  logic [2:0]        w_fill_nxt;
  logic              w_match;
  logic              w_last;

  // Round-robin pick: the nearest requester above the last-served channel wins.
  // Scanning from the farthest offset down means the nearest one is assigned last.
  always_comb begin
    w_win_vld = 1'b0;
    w_win_id  = {IDW{1'b0}};
    w_cand    = {IDW{1'b0}};
    for (int k = NCH; k >= 1; k--) begin
      w_cand = r_ptr + IDW'(k);
      if (req[w_cand]) begin
        w_win_vld = 1'b1;
        w_win_id  = w_cand;
      end else begin
        w_win_vld = w_win_vld;
        w_win_id  = w_win_id;
      end
    end
  end

  // Select the winner's word and build its one-hot grant.
  always_comb begin
    w_word   = {WIDTH{1'b0}};
    w_onehot = {{(NCH-1){1'b0}}, 1'b1} << w_win_id;
    for (int i = 0; i < NCH; i++) begin
      if (w_win_id == IDW'(i)) begin
        w_word = data[i*WIDTH +: WIDTH];
      end else begin
        w_word = w_word;
      end
    end
  end

  // Detector window update for the bit leaving the shift register this cycle.
  always_comb begin
    w_bit      = r_shreg[WIDTH-1];
    w_win_nxt  = {r_win[2:0], w_bit};
    w_fill_nxt = (r_fill == 3'd4) ? 3'd4 : (r_fill + 3'd1);
    w_match    = (w_fill_nxt == 3'd4) && (w_win_nxt == PAT);
    w_last     = (r_bitcnt == BCW'(WIDTH-1));
  end

  // Controller next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_win_vld) begin
          w_state_nxt = S_SHIFT;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_SHIFT: begin
        if (w_last) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_SHIFT;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Controller state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath and registered outputs: grant capture, serial scan, result report.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr     <= IDW'(NCH-1);
      r_shreg   <= {WIDTH{1'b0}};
      r_bitcnt  <= {BCW{1'b0}};
      r_win     <= 4'b0000;
      r_fill    <= 3'd0;
      r_cnt     <= {CNTW{1'b0}};
      gnt       <= {NCH{1'b0}};
      busy      <= 1'b0;
      found     <= 1'b0;
      done      <= 1'b0;
      done_id   <= {IDW{1'b0}};
      match_cnt <= {CNTW{1'b0}};
    end else begin
      found <= 1'b0;
      done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_win_vld) begin
            gnt      <= w_onehot;
            busy     <= 1'b1;
            r_shreg  <= w_word;
            r_bitcnt <= {BCW{1'b0}};
            r_win    <= 4'b0000;
            r_fill   <= 3'd0;
            r_cnt    <= {CNTW{1'b0}};
            r_ptr    <= w_win_id;
          end
        end
        S_SHIFT: begin
          r_shreg  <= {r_shreg[WIDTH-2:0], 1'b0};
          r_bitcnt <= r_bitcnt + {{(BCW-1){1'b0}}, 1'b1};
          r_win    <= w_win_nxt;
          if (w_match) begin
            // Emptying the window makes matches non-overlapping.
            found  <= 1'b1;
            r_fill <= 3'd0;
            if (r_cnt != CNT_MAX) begin
              r_cnt <= r_cnt + CNT_ONE;
            end
          end else begin
            r_fill <= w_fill_nxt;
          end
        end
        S_DONE: begin
          done      <= 1'b1;
          done_id   <= r_ptr;
          match_cnt <= r_cnt;
          gnt       <= {NCH{1'b0}};
          busy      <= 1'b0;
        end
        default: begin
          gnt  <= {NCH{1'b0}};
          busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_scan_arbiter.sv
// Self-checking bench for seq_scan_arbiter: a job-level timeline model
// checked on every cycle, plus directed scenarios with literal expectations.
module tb_seq_scan_arbiter;

  localparam int NCH = 4;
  localparam int IDW = 2;
  localparam int WIDTH = 16;
  localparam logic [3:0] PAT = 4'b1011;
  localparam int CNTW = 5;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [NCH-1:0]       req = '0;
  logic [NCH*WIDTH-1:0] data = '0;
  logic [NCH-1:0]       gnt;
  logic                 busy, found, done;
  logic [IDW-1:0]       done_id;
  logic [CNTW-1:0]      match_cnt;

  int n_cmp = 0;
  int n_err = 0;

  seq_scan_arbiter #(.NCH(NCH), .IDW(IDW), .WIDTH(WIDTH), .PAT(PAT), .CNTW(CNTW)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .data(data), .gnt(gnt), .busy(busy),
    .found(found), .done(done), .done_id(done_id), .match_cnt(match_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (job timeline) ----------------
  int               n_edge = 0;
  bit               m_active = 1'b0;
  int               m_start = 0;
  int               m_id = 0;
  int               m_ptr = NCH - 1;
  int               m_cnt = 0;
  logic [WIDTH-1:0] m_fmask = '0;
  logic [WIDTH-1:0] m_word;
  int               m_pos;
  logic [NCH-1:0]   m_gnt = '0;
  logic             m_busy = 1'b0;
  logic             m_found = 1'b0;
  logic             m_done = 1'b0;
  int               m_done_id = 0;
  int               m_mcnt = 0;

  // A job granted at edge E processes bit j at edge E+1+j and reports at E+WIDTH+1.
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_active = 1'b0; m_ptr = NCH - 1; m_gnt = '0; m_busy = 1'b0;
        m_found = 1'b0; m_done = 1'b0; m_done_id = 0; m_mcnt = 0;
      end else begin
        n_edge++;
        m_found = 1'b0;
        m_done  = 1'b0;
        if (m_active) begin
          if (n_edge == m_start + WIDTH + 1) begin
            m_active = 1'b0; m_done = 1'b1; m_done_id = m_id; m_mcnt = m_cnt;
          end else if (n_edge > m_start) begin
            m_found = m_fmask[n_edge - m_start - 1];
          end
        end else if (req != '0) begin
          for (int k = NCH; k >= 1; k--) begin
            if (req[(m_ptr + k) % NCH]) m_id = (m_ptr + k) % NCH;
          end
          m_ptr = m_id; m_active = 1'b1; m_start = n_edge;
          m_word = data[m_id*WIDTH +: WIDTH];
          m_fmask = '0; m_cnt = 0; m_pos = 0;
          // Greedy leftmost non-overlapping search over the MSB-first bit stream.
          while (m_pos <= WIDTH - 4) begin
            if (m_word[WIDTH-1-m_pos -: 4] == PAT) begin
              m_fmask[m_pos + 3] = 1'b1; m_cnt++; m_pos += 4;
            end else begin
              m_pos++;
            end
          end
        end
        m_gnt  = m_active ? (4'b0001 << m_id) : 4'b0000;
        m_busy = m_active;
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("gnt", gnt, m_gnt);
      chk("busy", busy, m_busy);
      chk("found", found, m_found);
      chk("done", done, m_done);
      chk("done_id", done_id, m_done_id);
      chk("match_cnt", match_cnt, m_mcnt);
    end
  end

  // ---------------- directed helpers ----------------
  task automatic wait_gnt();
    int c = 0;
    do begin @(negedge clk); c++; end while (gnt == '0 && c < 20);
    chk("gnt_seen", {31'd0, gnt != '0}, 32'd1);
  endtask

  task automatic wait_done(output int lat, output int nf);
    lat = 0; nf = 0;
    do begin
      @(negedge clk); lat++;
      if (found) nf++;
    end while (!done && lat < 40);
    chk("done_seen", {31'd0, done}, 32'd1);
  endtask

  task automatic do_job(input logic [3:0] r, input int ch, input logic [15:0] w,
                        input int exp_cnt, input string tag);
    int lat, nf;
    data[ch*WIDTH +: WIDTH] = w;
    req = r;
    wait_gnt();
    chk({tag, "_gnt"}, gnt, 32'd1 << ch);
    chk({tag, "_busy"}, busy, 32'd1);
    req = '0;
    wait_done(lat, nf);
    chk({tag, "_latency"}, lat, 32'd17);
    chk({tag, "_done_id"}, done_id, ch);
    chk({tag, "_match_cnt"}, match_cnt, exp_cnt);
    chk({tag, "_found_pulses"}, nf, exp_cnt);
    chk({tag, "_gnt_at_done"}, gnt, 32'd0);
    @(negedge clk);
  endtask

  int lat, nf, ndone;
  logic [3:0] order [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  int ord_id [5] = '{0, 1, 2, 3, 0};
  int ord_cnt [5] = '{1, 2, 3, 2, 1};

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_gnt", gnt, 32'd0);
    chk("rst_busy", busy, 32'd0);
    chk("rst_done", done, 32'd0);
    chk("rst_match_cnt", match_cnt, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1..3: single jobs and non-overlap
    do_job(4'b0001, 0, 16'hB000, 1, "t1");
    do_job(4'b0010, 1, 16'hB600, 1, "t2");
    do_job(4'b0100, 2, 16'hBBBB, 4, "t3a");
    do_job(4'b0100, 2, 16'h0000, 0, "t3b");

    // 4: pointer back to NCH-1, then all channels requesting continuously
    rst_n = 1'b0;
    #1;
    chk("rst2_gnt", gnt, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    data = {16'h0B0B, 16'hBBB0, 16'hBB00, 16'hB000};
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      if (k == 0) wait_gnt();
      else @(negedge clk);
      chk("t4_order", gnt, order[k]);
      if (k == 4) req = '0;
      wait_done(lat, nf);
      chk("t4_latency", lat, 32'd17);
      chk("t4_done_id", done_id, ord_id[k]);
      chk("t4_match_cnt", match_cnt, ord_cnt[k]);
    end
    @(negedge clk);

    // 5: req dropped after grant, second request arrives mid-job
    data[0*WIDTH +: WIDTH] = 16'hB000;
    req = 4'b0001;
    wait_gnt();
    chk("t5_gnt", gnt, 32'd1);
    req = '0;
    repeat (3) @(negedge clk);
    data[2*WIDTH +: WIDTH] = 16'h000B;
    req = 4'b0100;
    wait_done(lat, nf);
    chk("t5_latency", lat + 3, 32'd17);
    chk("t5_done_id", done_id, 32'd0);
    chk("t5_match_cnt", match_cnt, 32'd1);
    @(negedge clk);
    chk("t5_second_gnt", gnt, 32'd4);
    req = '0;
    wait_done(lat, nf);
    chk("t5b_done_id", done_id, 32'd2);
    chk("t5b_match_cnt", match_cnt, 32'd1);
    @(negedge clk);

    // 6: reset in the 5th shift cycle (a found pulse is live at that moment)
    data[1*WIDTH +: WIDTH] = 16'hBB00;
    req = 4'b0010;
    wait_gnt();
    chk("t6_gnt", gnt, 32'd2);
    req = '0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_gnt", gnt, 32'd0);
    chk("t6_rst_busy", busy, 32'd0);
    chk("t6_rst_found", found, 32'd0);
    chk("t6_rst_done", done, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("t6_no_done", ndone, 32'd0);
    do_job(4'b1000, 3, 16'hB0BB, 3, "t6b");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
